// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one combinationally-read DMEM between the core port
// and a debug/loader port. The core has priority, a saturating wait counter
// guarantees debug progress, and dbg_lock holds the grant across a burst.
module dmem_arbiter #(
  parameter int DW       = 64,
  parameter int AW       = 64,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  input  logic          core_we,
  input  logic          core_re,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  input  logic          dbg_valid,
  input  logic          dbg_we,
  input  logic          dbg_lock,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ready,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata,
  output logic          grant_dbg
);

  typedef enum logic {NORMAL, DBG_LOCK} state_t;

  localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_wait_cnt;
  logic [3:0]    w_wait_nxt;
  logic          r_rvalid;
  logic [DW-1:0] r_rdata;
  logic          w_core_req;
  logic          w_dbg_win;
  logic          w_core_win;
  logic          w_dbg_beat;

  // Saturating increment of the starvation counter.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= LP_MAX_WAIT) ? LP_MAX_WAIT : v + 4'd1;
  endfunction

  assign w_core_req = core_we | core_re;
  assign w_dbg_beat = dbg_valid & w_dbg_win;

  // Grant decision: reset forces both grants off; lock gives debug absolute priority.
  always_comb begin
    w_dbg_win  = 1'b0;
    w_core_win = 1'b0;
    if (!rst) begin
      if (r_state == DBG_LOCK) begin
        w_dbg_win = dbg_valid;
      end else begin
        w_dbg_win = dbg_valid & (~w_core_req | (r_wait_cnt == LP_MAX_WAIT));
      end
      w_core_win = w_core_req & ~w_dbg_win;
    end
  end

  // Next state and next wait count.
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = 4'd0;
    if (w_dbg_beat) begin
      w_state_nxt = dbg_lock ? DBG_LOCK : NORMAL;
    end
    if (dbg_valid && !w_dbg_win) begin
      w_wait_nxt = sat_inc(r_wait_cnt);
    end
  end

  // Memory mux: route the winner's fields to DMEM, zeros when nobody wins.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (w_dbg_win) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_we    = dbg_we;
      mem_re    = ~dbg_we;
    end else if (w_core_win) begin
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
      mem_we    = core_we;
      mem_re    = core_re & ~core_we;
    end
  end

  // Arbitration state, starvation counter and registered debug read return.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= NORMAL;
      r_wait_cnt <= 4'd0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_rvalid   <= w_dbg_beat & ~dbg_we;
      if (w_dbg_beat && !dbg_we) begin
        r_rdata <= mem_rdata;
      end
    end
  end

  assign core_rdata = mem_rdata;
  assign core_stall = w_core_req & ~w_core_win;
  assign dbg_ready  = w_dbg_win;
  assign grant_dbg  = w_dbg_win;
  assign dbg_rvalid = r_rvalid;
  assign dbg_rdata  = r_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural DMEM (MAX_WAIT=4).
module tb_dmem_arbiter;

  localparam int DW = 64;
  localparam int AW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_we;
  logic          core_re;
  logic [DW-1:0] core_rdata;
  logic          core_stall;
  logic          dbg_valid;
  logic          dbg_we;
  logic          dbg_lock;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_ready;
  logic          dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_rdata;
  logic          grant_dbg;

  logic [DW-1:0] dmem [0:31];

  int n_chk  = 0;
  int n_pass = 0;

  dmem_arbiter #(.DW(DW), .AW(AW), .MAX_WAIT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_we    (core_we),
    .core_re    (core_re),
    .core_rdata (core_rdata),
    .core_stall (core_stall),
    .dbg_valid  (dbg_valid),
    .dbg_we     (dbg_we),
    .dbg_lock   (dbg_lock),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_ready  (dbg_ready),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata),
    .grant_dbg  (grant_dbg)
  );

  always #5 clk = ~clk;

  // DMEM model: combinational read, posedge write, 8-byte words.
  always @(posedge clk) begin
    if (mem_we) dmem[mem_addr[7:3]] <= mem_wdata;
  end
  assign mem_rdata = dmem[mem_addr[7:3]];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance to 1 time unit after the next posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic core_set(input logic we, input logic re, input logic [63:0] a, input logic [63:0] d);
    core_we = we; core_re = re; core_addr = a; core_wdata = d;
  endtask

  task automatic dbg_set(input logic v, input logic we, input logic lk, input logic [63:0] a, input logic [63:0] d);
    dbg_valid = v; dbg_we = we; dbg_lock = lk; dbg_addr = a; dbg_wdata = d;
  endtask

  initial begin
    rst = 1'b1;
    core_set(1'b0, 1'b1, 64'h0, 64'h0);
    dbg_set(1'b1, 1'b1, 1'b0, 64'h0, 64'h0);
    #2;
    // Reset: grants forced off, stall mirrors the core request.
    chk("rst_rvalid", dbg_rvalid, 1'b0);
    chk("rst_rdata",  dbg_rdata,  64'h0);
    chk("rst_ready",  dbg_ready,  1'b0);
    chk("rst_gdbg",   grant_dbg,  1'b0);
    chk("rst_we",     mem_we,     1'b0);
    chk("rst_re",     mem_re,     1'b0);
    chk("rst_stall",  core_stall, 1'b1);
    step();
    step();
    rst = 1'b0;
    core_set(1'b0, 1'b0, 64'h0, 64'h0);
    dbg_set(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    step();

    // Core only: write then read back.
    core_set(1'b1, 1'b0, 64'h0, 64'h8);
    #2;
    chk("c_wr_we",    mem_we,     1'b1);
    chk("c_wr_stall", core_stall, 1'b0);
    chk("c_wr_ready", dbg_ready,  1'b0);
    step();
    core_set(1'b0, 1'b1, 64'h0, 64'h0);
    #2;
    chk("c_rd_data",  core_rdata, 64'h8);
    chk("c_rd_re",    mem_re,     1'b1);
    chk("c_rd_stall", core_stall, 1'b0);
    step();
    core_set(1'b1, 1'b0, 64'h8, 64'h1234);
    step();
    // Simultaneous we/re is a write.
    core_set(1'b1, 1'b1, 64'h10, 64'h55);
    #2;
    chk("c_wr_re_re", mem_re, 1'b0);
    chk("c_wr_re_we", mem_we, 1'b1);
    step();

    // Debug read with idle core.
    core_set(1'b0, 1'b0, 64'h0, 64'h0);
    dbg_set(1'b1, 1'b0, 1'b0, 64'h8, 64'h0);
    #2;
    chk("d_rd_ready", dbg_ready, 1'b1);
    chk("d_rd_gdbg",  grant_dbg, 1'b1);
    chk("d_rd_addr",  mem_addr,  64'h8);
    chk("d_rd_re",    mem_re,    1'b1);
    step();
    dbg_set(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    #2;
    chk("d_rd_rvalid", dbg_rvalid, 1'b1);
    chk("d_rd_rdata",  dbg_rdata,  64'h1234);
    step();
    chk("d_rd_rvalid_off", dbg_rvalid, 1'b0);
    chk("d_rd_hold",       dbg_rdata,  64'h1234);

    // Starvation: debug write waits 4 cycles under a continuous core read.
    core_set(1'b0, 1'b1, 64'h0, 64'h0);
    dbg_set(1'b1, 1'b1, 1'b0, 64'h18, 64'h77);
    for (int c = 0; c < 4; c++) begin
      #2;
      chk($sformatf("st_c%0d_stall", c), core_stall, 1'b0);
      chk($sformatf("st_c%0d_ready", c), dbg_ready,  1'b0);
      step();
    end
    #2;
    chk("st_c4_ready", dbg_ready,  1'b1);
    chk("st_c4_stall", core_stall, 1'b1);
    chk("st_c4_we",    mem_we,     1'b1);
    chk("st_c4_addr",  mem_addr,   64'h18);
    step();
    #2;
    chk("st_c5_stall", core_stall, 1'b0);
    chk("st_c5_ready", dbg_ready,  1'b0);
    step();
    dbg_set(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    core_set(1'b0, 1'b1, 64'h18, 64'h0);
    #2;
    chk("st_rdback", core_rdata, 64'h77);
    step();

    // Locked burst under continuous core requests.
    core_set(1'b0, 1'b1, 64'h20, 64'h0);
    dbg_set(1'b1, 1'b1, 1'b1, 64'h0, 64'hA);
    for (int c = 0; c < 4; c++) begin
      #2;
      chk($sformatf("lb_w%0d_ready", c), dbg_ready, 1'b0);
      step();
    end
    #2;
    chk("lb_b1_ready", dbg_ready, 1'b1);
    step();
    dbg_set(1'b1, 1'b1, 1'b1, 64'h8, 64'hB);
    #2;
    chk("lb_b2_ready", dbg_ready,  1'b1);
    chk("lb_b2_stall", core_stall, 1'b1);
    step();
    dbg_set(1'b1, 1'b1, 1'b0, 64'h10, 64'hC);
    #2;
    chk("lb_b3_ready", dbg_ready,  1'b1);
    chk("lb_b3_stall", core_stall, 1'b1);
    step();
    dbg_set(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    #2;
    chk("lb_after_stall", core_stall, 1'b0);
    chk("lb_after_gdbg",  grant_dbg,  1'b0);
    step();
    // Back in NORMAL: a fresh contended debug request loses.
    dbg_set(1'b1, 1'b0, 1'b0, 64'h0, 64'h0);
    #2;
    chk("lb_normal_ready", dbg_ready,  1'b0);
    chk("lb_normal_stall", core_stall, 1'b0);
    step();
    dbg_set(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    core_set(1'b0, 1'b1, 64'h0, 64'h0);
    #2;
    chk("lb_rd0", core_rdata, 64'hA);
    step();
    core_set(1'b0, 1'b1, 64'h8, 64'h0);
    #2;
    chk("lb_rd1", core_rdata, 64'hB);
    step();
    core_set(1'b0, 1'b1, 64'h10, 64'h0);
    #2;
    chk("lb_rd2", core_rdata, 64'hC);
    step();

    // Lock with a debug gap: core fills the gap, debug regains immediately.
    core_set(1'b0, 1'b0, 64'h0, 64'h0);
    dbg_set(1'b1, 1'b1, 1'b1, 64'h28, 64'h11);
    #2;
    chk("gap_enter_ready", dbg_ready, 1'b1);
    step();
    dbg_set(1'b0, 1'b0, 1'b1, 64'h0, 64'h0);
    core_set(1'b0, 1'b1, 64'h28, 64'h0);
    #2;
    chk("gap1_stall", core_stall, 1'b0);
    chk("gap1_data",  core_rdata, 64'h11);
    step();
    #2;
    chk("gap2_stall", core_stall, 1'b0);
    step();
    dbg_set(1'b1, 1'b1, 1'b0, 64'h30, 64'h22);
    #2;
    chk("gap_re_ready", dbg_ready,  1'b1);
    chk("gap_re_stall", core_stall, 1'b1);
    step();

    // Reset mid-burst, one cycle after an accepted locked read.
    core_set(1'b0, 1'b0, 64'h0, 64'h0);
    dbg_set(1'b1, 1'b0, 1'b1, 64'h28, 64'h0);
    #2;
    chk("mr_ready", dbg_ready, 1'b1);
    step();
    core_set(1'b0, 1'b1, 64'h0, 64'h0);
    chk("mr_rvalid_pre", dbg_rvalid, 1'b1);
    rst = 1'b1;
    #2;
    chk("mr_rvalid", dbg_rvalid, 1'b0);
    chk("mr_we",     mem_we,     1'b0);
    chk("mr_re",     mem_re,     1'b0);
    chk("mr_dready", dbg_ready,  1'b0);
    chk("mr_stall",  core_stall, 1'b1);
    step();
    rst = 1'b0;
    #2;
    chk("mr_post_ready", dbg_ready,  1'b0);
    chk("mr_post_stall", core_stall, 1'b0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single 64-bit data memory between the riscV core's DMEM port and a debug/loader port.
- Lets a bench or debug host preload and inspect DMEM while the core runs.
- The core has priority. A starvation counter guarantees debug progress. An optional lock gives debug exclusive back-to-back bursts.
- Sits between the core's addrData/wrData/MemWrite/MemRead signals and the DMEM array. The memory reads combinationally and writes on posedge.

Parameters:
- DW, 64, data width of core, debug and memory paths.
- AW, 64, address width (byte address).
- MAX_WAIT, 4, consecutive denied debug cycles before debug wins a contended cycle; range 1..15.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  reset, asynchronous, active-high.
- core_addr  in  AW  core byte address.
- core_wdata  in  DW  core store data.
- core_we  in  1  core write request.
- core_re  in  1  core read request.
- core_rdata  out  DW  read data to core.
- core_stall  out  1  core request not granted this cycle.
- dbg_valid  in  1  debug request valid.
- dbg_we  in  1  1=write, 0=read.
- dbg_lock  in  1  keep exclusive grant after this beat.
- dbg_addr  in  AW  debug byte address.
- dbg_wdata  in  DW  debug write data.
- dbg_ready  out  1  debug beat accepted this cycle.
- dbg_rvalid  out  1  one-cycle pulse: dbg_rdata holds read result.
- dbg_rdata  out  DW  registered debug read data.
- mem_addr  out  AW  to DMEM.
- mem_wdata  out  DW  to DMEM.
- mem_we  out  1  to DMEM.
- mem_re  out  1  to DMEM.
- mem_rdata  in  DW  combinational DMEM read data.
- grant_dbg  out  1  status: debug owns memory this cycle.

Behaviour:
- Request definitions
  - core_req = core_we | core_re.
  - If core_we and core_re are both high, treat it as a write: mem_re=0.
- FSM states
  - NORMAL: reset state.
  - DBG_LOCK.
- Grant in NORMAL (combinational)
  - Only core_req high: core wins.
  - Only dbg_valid high: debug wins.
  - Both high: debug wins iff wait_cnt==MAX_WAIT, else core.
- Grant in DBG_LOCK (combinational)
  - dbg_valid high: debug wins unconditionally.
  - dbg_valid low: core may win, so no idle bubble is wasted.
- FSM transitions
  - NORMAL->DBG_LOCK on an accepted debug beat with dbg_lock=1.
  - DBG_LOCK->NORMAL on an accepted debug beat with dbg_lock=0.
  - Otherwise hold state.
- wait_cnt (4 bits)
  - Increments, saturating at MAX_WAIT, on cycles where dbg_valid=1 and debug loses.
  - Cleared when debug wins or dbg_valid=0.
- Handshake
  - dbg_ready = debug wins. A beat transfers when dbg_valid & dbg_ready.
  - Debug holds addr/data/we/lock stable until ready.
  - core_stall = core_req & ~core wins. The core holds its request stable while stalled.
- Memory mux
  - mem_* carry the winner's fields.
  - With no winner: mem_we=mem_re=0, mem_addr=0, mem_wdata=0.
  - grant_dbg = debug wins.
- Latency
  - Core read: 0 cycles. core_rdata = mem_rdata combinationally, meaningful only when granted.
  - Core or debug write: lands at the posedge of the grant cycle.
  - Debug read: dbg_rdata captures mem_rdata at the posedge ending the accepted read cycle; dbg_rvalid=1 for exactly the next cycle. dbg_rdata holds until the next accepted read.
  - Debug writes never raise dbg_rvalid.
- Reset (async, active-high)
  - State=NORMAL, wait_cnt=0, dbg_rvalid=0, dbg_rdata=0.
  - While rst=1, grants are forced off: mem_we=mem_re=0, dbg_ready=0, grant_dbg=0, core_stall=core_req.
  - Reset mid-burst abandons the lock and any pending rvalid.
  - The first cycle after release uses NORMAL priority.
- Boundary cases
  - MAX_WAIT=1: a contended debug request wins on its second cycle.
  - Back-to-back debug reads give back-to-back rvalid pulses.
  - Addresses pass through untouched; alignment is the memory's concern.

Test Plan:
- Core only: core_we=1, addr 0x0, wdata 8, then core_re=1, addr 0x0 -> mem_we=1 in the first cycle; then core_rdata=8; core_stall=0 throughout; dbg_ready=0.
- Debug read: DMEM[1]=0x1234, dbg_valid=1, we=0, addr 0x8, core idle -> dbg_ready=1 that cycle; next cycle dbg_rvalid=1 and dbg_rdata=0x1234; following cycle dbg_rvalid=0.
- Starvation, MAX_WAIT=4: core_re held continuously and debug write held continuously -> core granted cycles 0-3; cycle 4 has dbg_ready=1, core_stall=1 and mem_we=1; cycle 5 core granted with wait_cnt=0.
- Locked burst: debug writes 0xA, 0xB, 0xC to 0x0, 0x8, 0x10 with lock=1,1,0 under continuous core requests -> first beat after 4 waits; beats 2-3 accepted back-to-back with core_stall=1; the cycle after beat 3, the core is granted and the state is NORMAL; DMEM reads back 0xA, 0xB, 0xC.
- Lock with debug gap: in DBG_LOCK, drop dbg_valid for 2 cycles while core_re=1 -> core granted both cycles; debug regains the grant immediately on reassert.
- Reset mid-burst: assert rst in DBG_LOCK one cycle after an accepted debug read -> dbg_rvalid=0 and mem_we=mem_re=0 during reset; after release a contended request goes to the core with wait_cnt=0.
